// File: rtl/window_comp_pkg.sv
// Shared definitions for the window computation actor: CFDF mode codes,
// level-1 invoke FSM state codes and a width helper.
package window_comp_pkg;

  localparam logic [1:0] SETUP_COMP = 2'b00;
  localparam logic [1:0] COMP       = 2'b01;
  localparam logic [1:0] OUTPUT     = 2'b10;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] UPDATE = 3'd3;
  localparam logic [2:0] END    = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int log2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // CFDF mode sequence; the illegal code recovers to SETUP_COMP.
  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    case (mode)
      SETUP_COMP: return COMP;
      COMP:       return OUTPUT;
      default:    return SETUP_COMP;
    endcase
  endfunction

endpackage

// File: rtl/window_comp_invoke_fsm1_firing_watchdog.sv
// Counts cycles spent waiting for the level-2 FSM; expired flags the last
// allowed cycle of the wait.
module firing_watchdog
  import window_comp_pkg::*;
#(
  parameter int timeout = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int         W    = log2(timeout);
  localparam logic [W-1:0] LAST = W'(timeout - 1);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || i_clear) r_count <= '0;
    else if (i_enable)  r_count <= r_count + 1'b1;
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/window_comp_invoke_fsm1.sv
// Level-1 invoke controller: launches one level-2 firing per scheduler
// invoke, steps the CFDF mode, counts firings and flags a stalled firing.
module window_comp_invoke_fsm1
  import window_comp_pkg::*;
#(
  parameter int timeout     = 64,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   invoke_in,
  input  logic                   done_in,
  output logic                   start_out,
  output logic [1:0]             mode_out,
  output logic                   busy_out,
  output logic                   invoke_done_out,
  output logic [count_width-1:0] fire_count_out,
  output logic                   error_out
);

  logic [2:0]             r_state;
  logic [2:0]             w_state_next;
  logic [1:0]             r_mode;
  logic [count_width-1:0] r_fire_count;
  logic                   w_expired;

  firing_watchdog #(.timeout(timeout)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state == START),
    .i_enable  (r_state == WAIT),
    .o_expired (w_expired)
  );

  // NOTE: next state defaults to the current state before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (invoke_in) w_state_next = START;
      START:   w_state_next = WAIT;
      WAIT: begin
        // A done arriving on the expiry cycle still completes the firing.
        if (done_in)        w_state_next = UPDATE;
        else if (w_expired) w_state_next = ERROR;
      end
      UPDATE:  w_state_next = END;
      END:     w_state_next = IDLE;
      ERROR:   w_state_next = ERROR;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mode       <= SETUP_COMP;
      r_fire_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == UPDATE) begin
        r_mode       <= next_mode(r_mode);
        r_fire_count <= r_fire_count + 1'b1;
      end
    end
  end

  assign start_out       = (r_state == START);
  assign busy_out        = (r_state != IDLE) && (r_state != ERROR);
  assign invoke_done_out = (r_state == END);
  assign error_out       = (r_state == ERROR);
  assign mode_out        = r_mode;
  assign fire_count_out  = r_fire_count;

endmodule

// File: tb/tb_window_comp_invoke_fsm1.sv
// Directed bench for the level-1 invoke FSM with a short watchdog and a
// narrow firing counter so expiry and wrap are reachable quickly.
module tb_window_comp_invoke_fsm1;

  localparam int TMO = 8;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          invoke_in = 1'b0;
  logic          done_in = 1'b0;
  logic          start_out, busy_out, invoke_done_out, error_out;
  logic [1:0]    mode_out;
  logic [CW-1:0] fire_count_out;

  int n_total = 0;
  int n_bad   = 0;
  logic [1:0]    exp_mode  = 2'b00;
  logic [CW-1:0] exp_count = '0;

  window_comp_invoke_fsm1 #(.timeout(TMO), .count_width(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .invoke_in       (invoke_in),
    .done_in         (done_in),
    .start_out       (start_out),
    .mode_out        (mode_out),
    .busy_out        (busy_out),
    .invoke_done_out (invoke_done_out),
    .fire_count_out  (fire_count_out),
    .error_out       (error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs changed and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {start, busy, invoke_done, error}
  function automatic logic [31:0] flags();
    return {28'd0, start_out, busy_out, invoke_done_out, error_out};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_mode  = 2'b00;
    exp_count = '0;
  endtask

  // One firing from IDLE; done_in is sampled dly edges after the invoke edge.
  task automatic fire(input string tag, input int dly, input logic [1:0] post_mode);
    invoke_in = 1'b1;
    step();
    invoke_in = 1'b0;
    check({tag, "_start"}, flags(), 32'b1100);
    check({tag, "_mode"}, mode_out, exp_mode);
    repeat (dly - 1) step();
    check({tag, "_wait"}, flags(), 32'b0100);
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    check({tag, "_upd"}, flags(), 32'b0100);
    step();
    exp_mode = post_mode;
    exp_count = exp_count + 1'b1;
    check({tag, "_done"}, flags(), 32'b0110);
    check({tag, "_newmode"}, mode_out, exp_mode);
    check({tag, "_count"}, fire_count_out, exp_count);
    step();
    check({tag, "_idle"}, flags(), 32'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int starts;

    // Reset held with invoke asserted.
    rst = 1'b1;
    invoke_in = 1'b1;
    step();
    step();
    check("rst_flags", flags(), 32'b0000);
    check("rst_mode", mode_out, 2'b00);
    check("rst_count", fire_count_out, 0);
    invoke_in = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    check("idle_flags", flags(), 32'b0000);

    // Single firing: done 5 edges after invoke, completion 2 edges later.
    fire("single", 5, 2'b01);

    // Mode sequence from a fresh reset.
    do_reset();
    fire("seq0", 4, 2'b01);
    fire("seq1", 4, 2'b10);
    check("seq1_m", mode_out, 2'b10);
    fire("seq2", 4, 2'b00);
    fire("seq3", 4, 2'b01);
    check("seq_count4", fire_count_out, 4);

    // invoke held high across one firing: exactly one start pulse.
    starts = 0;
    invoke_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) done_in = 1'b1;
      step();
      done_in = 1'b0;
      if (start_out) starts++;
    end
    invoke_in = 1'b0;
    check("hold_starts", starts, 1);
    check("hold_mode", mode_out, 2'b10);
    check("hold_count", fire_count_out, 5);
    exp_mode = 2'b10;
    exp_count = 3'd5;
    step();
    check("hold_idle", flags(), 32'b0000);

    // done in IDLE is ignored.
    done_in = 1'b1;
    step();
    check("idle_done_flags", flags(), 32'b0000);
    step();
    done_in = 1'b0;
    check("idle_done_flags2", flags(), 32'b0000);
    check("idle_done_count", fire_count_out, 5);

    // Counter wrap: 5 -> 6 -> 7 -> 0.
    fire("wrap0", 2, 2'b00);
    fire("wrap1", 3, 2'b01);
    fire("wrap2", 2, 2'b10);
    check("wrap_zero", fire_count_out, 0);

    // Watchdog: no done; error rises 9 edges after the invoke edge.
    invoke_in = 1'b1;
    step();
    invoke_in = 1'b0;
    check("tmo_start", flags(), 32'b1100);
    repeat (8) step();
    check("tmo_last_wait", flags(), 32'b0100);
    step();
    check("tmo_error", flags(), 32'b0001);
    invoke_in = 1'b1;
    done_in = 1'b1;
    repeat (4) step();
    check("tmo_sticky", flags(), 32'b0001);
    check("tmo_mode", mode_out, 2'b10);
    check("tmo_count", fire_count_out, 0);
    invoke_in = 1'b0;
    done_in = 1'b0;
    do_reset();
    check("tmo_cleared", flags(), 32'b0000);
    check("tmo_rst_mode", mode_out, 2'b00);

    // done on the expiry cycle completes normally.
    fire("coinc", 9, 2'b01);
    repeat (10) step();
    check("coinc_noerr", flags(), 32'b0000);

    // Reset in the middle of the COMP firing's WAIT.
    invoke_in = 1'b1;
    step();
    invoke_in = 1'b0;
    check("mid_mode", mode_out, 2'b01);
    repeat (3) step();
    check("mid_wait", flags(), 32'b0100);
    do_reset();
    check("mid_flags", flags(), 32'b0000);
    check("mid_mode_rst", mode_out, 2'b00);
    check("mid_count_rst", fire_count_out, 0);
    repeat (4) step();
    check("mid_nodone", flags(), 32'b0000);
    fire("after", 3, 2'b01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
